// File: rtl/ibex_pkg.sv
// ============================================================================
// ibex_pkg : interrupt types, cause encodings and CSR bit positions
// Revision : 1.0
// ============================================================================
`default_nettype none

package ibex_pkg;

  typedef struct packed {
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [14:0] irq_fast;
  } irqs_t;

  typedef enum logic [5:0] {
    EXC_CAUSE_INSN_ADDR_MISA  = {1'b0, 5'd00},
    EXC_CAUSE_IRQ_SOFTWARE_M  = {1'b1, 5'd03},
    EXC_CAUSE_IRQ_TIMER_M     = {1'b1, 5'd07},
    EXC_CAUSE_IRQ_EXTERNAL_M  = {1'b1, 5'd11},
    EXC_CAUSE_IRQ_NM          = {1'b1, 5'd31}
  } exc_cause_e;

  typedef enum logic [0:0] {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_e;

  localparam int unsigned CSR_MSIX_BIT       = 3;
  localparam int unsigned CSR_MTIX_BIT       = 7;
  localparam int unsigned CSR_MEIX_BIT       = 11;
  localparam int unsigned CSR_MFIX_BIT_LOW   = 16;
  localparam int unsigned CSR_MFIX_BIT_HIGH  = 30;

  parameter logic [4:0] IRQ_FAST_CAUSE_BASE = 5'd16;

endpackage

`default_nettype wire

// File: rtl/ibex_irq_ctrl.sv
// ============================================================================
// ibex_irq_ctrl : pending register, NMI edge latch and request/ack handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_irq_ctrl
  import ibex_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  irqs_t      irqs_i,
  input  logic       irq_nm_i,
  input  irqs_t      mie_i,
  input  logic       mstatus_mie_i,
  input  logic       debug_mode_i,
  input  logic       irq_ack_i,
  output logic       irq_req_o,
  output exc_cause_e irq_cause_o,
  output irqs_t      mip_o,
  output logic       nmi_pending_o
);

  irq_state_e state_q, state_d;
  exc_cause_e cause_q, cause_d;
  irqs_t      mip_q;
  logic       nm_q;
  logic       nmi_pending_q, nmi_pending_d;

  irqs_t      irq_en;
  logic       nmi_en;
  logic       nmi_accept;

  function automatic exc_cause_e fast_cause(input int unsigned idx);
    fast_cause = exc_cause_e'({1'b1, IRQ_FAST_CAUSE_BASE + 5'(idx)});
  endfunction

  // Descending scan so the lowest-indexed fast line is the last writer.
  function automatic exc_cause_e prio_cause(input logic nmi, input irqs_t en);
    prio_cause = EXC_CAUSE_INSN_ADDR_MISA;
    if (nmi) begin
      prio_cause = EXC_CAUSE_IRQ_NM;
    end else if (|en.irq_fast) begin
      for (int i = 14; i >= 0; i--) begin
        if (en.irq_fast[i]) prio_cause = fast_cause(i);
      end
    end else if (en.irq_external) begin
      prio_cause = EXC_CAUSE_IRQ_EXTERNAL_M;
    end else if (en.irq_software) begin
      prio_cause = EXC_CAUSE_IRQ_SOFTWARE_M;
    end else if (en.irq_timer) begin
      prio_cause = EXC_CAUSE_IRQ_TIMER_M;
    end
  endfunction

  function automatic logic still_eligible(input exc_cause_e cause, input irqs_t en);
    still_eligible = 1'b0;
    case (cause)
      EXC_CAUSE_IRQ_NM:         still_eligible = 1'b1;
      EXC_CAUSE_IRQ_EXTERNAL_M: still_eligible = en.irq_external;
      EXC_CAUSE_IRQ_SOFTWARE_M: still_eligible = en.irq_software;
      EXC_CAUSE_IRQ_TIMER_M:    still_eligible = en.irq_timer;
      default: begin
        for (int i = 0; i < 15; i++) begin
          if (cause == fast_cause(i)) still_eligible = en.irq_fast[i];
        end
      end
    endcase
  endfunction

  assign irq_en     = mip_q & mie_i & {18{mstatus_mie_i & ~debug_mode_i}};
  assign nmi_en     = nmi_pending_q & ~debug_mode_i;
  assign nmi_accept = (state_q == IRQ_REQ) && irq_ack_i && (cause_q == EXC_CAUSE_IRQ_NM);

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    nmi_pending_d = (irq_nm_i & ~nm_q) | (nmi_pending_q & ~nmi_accept);
    case (state_q)
      IRQ_IDLE: begin
        if (nmi_en || (|irq_en)) begin
          cause_d = prio_cause(nmi_en, irq_en);
          state_d = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        // Ack wins over loss of eligibility; an NMI is never withdrawn.
        if (irq_ack_i || !still_eligible(cause_q, irq_en)) begin
          state_d = IRQ_IDLE;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IRQ_IDLE;
      cause_q       <= EXC_CAUSE_INSN_ADDR_MISA;
      mip_q         <= '0;
      nm_q          <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      mip_q         <= irqs_i;
      nm_q          <= irq_nm_i;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign irq_req_o     = (state_q == IRQ_REQ);
  assign irq_cause_o   = cause_q;
  assign mip_o         = mip_q;
  assign nmi_pending_o = nmi_pending_q;

endmodule

`default_nettype wire

// File: doc/ibex_irq_ctrl.md
IBEX_IRQ_CTRL -- requirements
Module: ibex_irq_ctrl

Interface
REQ-001 The module SHALL have no parameters; all widths and encodings SHALL come from ibex_pkg (irqs_t, exc_cause_e, CSR_M*IX_BIT).
REQ-002 The module SHALL use one clock, clk_i, and an asynchronous, active-low reset, rst_ni.
REQ-003 Ports SHALL be as follows, clock and reset first.
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- irqs_i  in  irqs_t (18)  level-sensitive software, timer, external and fast[14:0] interrupt lines
- irq_nm_i  in  1  non-maskable interrupt line, edge-triggered
- mie_i  in  irqs_t  per-source enables, already unpacked by the CSR file
- mstatus_mie_i  in  1  global machine interrupt enable
- debug_mode_i  in  1  core is in debug mode
- irq_ack_i  in  1  controller has taken the presented interrupt
- irq_req_o  out  1  interrupt request to the controller
- irq_cause_o  out  exc_cause_e (6)  cause of the presented request
- mip_o  out  irqs_t  registered pending bits, read by the CSR file as mip
- nmi_pending_o  out  1  latched NMI is outstanding

Function
REQ-004 Pending register: mip_q SHALL sample irqs_i every cycle; mip_o SHALL equal mip_q.
REQ-005 NMI edge detect: nm_q SHALL hold irq_nm_i delayed by one cycle.
- Condition irq_nm_i & ~nm_q SHALL set nmi_pending_q.
- nmi_pending_q SHALL clear only on acceptance of an NMI request.
- If a new edge arrives in the same cycle as that acceptance, nmi_pending_q SHALL stay set.
- Further edges while nmi_pending_q is set SHALL NOT be counted.
REQ-006 Eligibility: a source is eligible when mip_q & mie_i & mstatus_mie_i & ~debug_mode_i is set for it.
- NMI is eligible when nmi_pending_q & ~debug_mode_i.
- mstatus_mie_i SHALL NOT affect NMI eligibility.
REQ-007 Fixed priority, highest first: NMI, fast[0] to fast[14] (lowest index wins), external, software, timer.
REQ-008 Cause encoding:
- NMI -> EXC_CAUSE_IRQ_NM
- fast[i] -> {1'b1, 5'd16+i}
- external, software and timer -> EXC_CAUSE_IRQ_EXTERNAL_M, EXC_CAUSE_IRQ_SOFTWARE_M and EXC_CAUSE_IRQ_TIMER_M
REQ-009 The FSM SHALL have two states, IDLE and REQ; irq_req_o SHALL equal (state==REQ) and be driven from a flop.
REQ-010 In IDLE, if any source is eligible, the FSM SHALL capture the winning cause into cause_q and move to REQ; otherwise it SHALL stay in IDLE.
REQ-011 In REQ, cause_q SHALL stay stable, with no preemption by a higher-priority source, until the FSM leaves REQ.
REQ-012 In REQ with irq_ack_i=1, the FSM SHALL return to IDLE, and the request SHALL count as accepted.
REQ-013 In REQ with irq_ack_i=0 and the captured source no longer eligible, the FSM SHALL withdraw to IDLE.
- An NMI request SHALL never be withdrawn.
- If ack and loss of eligibility coincide, ack SHALL take precedence.
REQ-014 After leaving REQ, the FSM SHALL spend at least one cycle in IDLE before the next request.
REQ-015 irq_ack_i while in IDLE SHALL be ignored.
REQ-016 irq_cause_o SHALL equal cause_q at all times.
REQ-017 Latency: irqs_i asserted at edge N (already enabled, FSM in IDLE) SHALL give mip_o=1 after edge N+1 and irq_req_o=1 after edge N+2.
REQ-018 nmi_pending_o SHALL equal nmi_pending_q.

Reset
REQ-019 While rst_ni=0, and asynchronously:
- mip_q, nm_q, nmi_pending_q and cause_q (EXC_CAUSE_INSN_ADDR_MISA) SHALL be 0.
- The FSM SHALL be in IDLE, so irq_req_o=0 and mip_o=0.
REQ-020 Reset asserted in REQ SHALL drop irq_req_o immediately, with no ack required.
REQ-021 irq_nm_i held high through reset deassertion SHALL be treated as an edge.

Structure
REQ-022 The FSM state enum (IRQ_IDLE, IRQ_REQ) SHALL be added to ibex_pkg.
REQ-023 The fast-interrupt cause base (5'd16) SHALL be added to ibex_pkg as a parameter.
REQ-024 The priority encoder SHALL be a combinational function inside the module; no sub-module is needed.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Timer only: mie.timer=1, mstatus_mie_i=1, irqs_i.irq_timer=1 at edge 10 -> irq_req_o=1 after edge 12 with cause 6'h27; ack at edge 14 -> irq_req_o=0 after edge 15.
- Simultaneous fast[3], fast[7] and external, all enabled -> cause 6'h33; after ack and with fast[3] deasserted, next request cause 6'h37.
- Priority lock: fast[5] presented, fast[1] asserted mid-request -> cause stays 6'h35 until ack.
- Withdrawal: external presented, mstatus_mie_i drops with no ack -> irq_req_o=0 next cycle.
- NMI with mstatus_mie_i=0: irq_nm_i pulse -> cause 6'h3F; debug_mode_i=1 blocks it; ack clears nmi_pending_o; a second edge on the ack cycle keeps it set.
- Reset in REQ -> irq_req_o=0 and mip_o=0 asynchronously; ack in IDLE -> no effect.
